// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio frame controller.
//   state_t       - frame controller FSM encoding
//   SAMPLE_W_DEF  - default bits per channel sample
//   FRAME_BITS    - bits in one stereo frame at the default sample width
//   frame_bits()  - stereo frame length for an arbitrary sample width
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int SAMPLE_W_DEF = 16;

    function automatic int frame_bits(input int w);
        return 2 * w;
    endfunction

    localparam int FRAME_BITS = frame_bits(SAMPLE_W_DEF);

endpackage

// File: rtl/sck_div.sv
// sck_div: serial bit-clock generator for the audio frame controller.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   run       in   divider enable; low holds sck=0 and the count at 0
//   sck       out  serial clock, SCK_HALF clks low then SCK_HALF clks high
//   fall_tick out  high in the clk cycle whose edge drives sck from 1 to 0
module sck_div #(
    parameter int SCK_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sck,
    output logic fall_tick
);

    localparam logic [7:0] TC = 8'(SCK_HALF - 1);

    logic [7:0] div_cnt;
    logic       tc;

    assign tc        = (div_cnt == TC);
    assign fall_tick = run && tc && sck;

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= 8'd0;
            sck     <= 1'b0;
        end else if (tc) begin
            div_cnt <= 8'd0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/audio_frame_ctrl.sv
// audio_frame_ctrl: stereo sample-pair serialiser for an I2S-style DAC link.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   run request (level)
//   sample_l/r   in   left/right two's complement samples
//   sample_valid in   source offers a pair
//   sample_ready out  one-deep pair buffer is empty
//   sck          out  serial bit clock
//   lrck         out  0 while left bits shift, 1 while right bits shift
//   sdin         out  serial data, MSB first
//   frame_start  out  one-clk pulse with each frame load
//   underrun     out  one-clk pulse when a frame loads with no pair pending
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | link quiet, waiting for en
// PRIME | en seen, waiting for the first buffered pair
// RUN   | sck running, shifting a frame; reloads at each frame end
module audio_frame_ctrl
    import audio_pkg::*;
#(
    parameter int SCK_HALF = 4,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sck,
    output logic                lrck,
    output logic                sdin,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FW = frame_bits(SAMPLE_W);
    localparam int BW = $clog2(FW);
    localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);
    localparam logic [BW-1:0] RIGHT_BIT = BW'(SAMPLE_W);

    state_t          state, state_nx;
    logic [FW-1:0]   nbuf;
    logic            nfull;
    logic [FW-1:0]   shreg;
    logic [BW-1:0]   bit_cnt;
    logic            run;
    logic            fall_tick;
    logic            accept;
    logic            load;
    logic            load_zero;
    logic            shift;

    assign run          = (state == ST_RUN);
    assign sample_ready = ~nfull;
    assign accept       = sample_valid && ~nfull;

    sck_div #(.SCK_HALF(SCK_HALF)) u_sck_div (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .sck       (sck),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_zero = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nx = ST_PRIME;
            end
            ST_PRIME: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                end else if (nfull) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fall_tick) begin
                    if (bit_cnt != LAST_BIT) begin
                        shift = 1'b1;
                    end else if (!en) begin
                        state_nx = ST_IDLE;
                    end else begin
                        load      = 1'b1;
                        load_zero = ~nfull;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // A pair accepted on an underrun boundary lands in nbuf, not the frame:
    // the zero frame is loaded from a constant, and the accept and the
    // buffer drain can never coincide because accept needs nfull=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            nbuf        <= '0;
            nfull       <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load;
            underrun    <= load_zero;
            if (load) begin
                shreg   <= load_zero ? '0 : nbuf;
                bit_cnt <= '0;
            end else if (shift) begin
                shreg   <= {shreg[FW-2:0], 1'b0};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (accept) begin
                nbuf  <= {sample_l, sample_r};
                nfull <= 1'b1;
            end else if (load && !load_zero) begin
                nfull <= 1'b0;
            end
        end
    end

    // shreg and bit_cnt keep the last frame after leaving RUN; gating keeps
    // the link quiet in IDLE/PRIME.
    assign sdin = run && shreg[FW-1];
    assign lrck = run && (bit_cnt >= RIGHT_BIT);

endmodule

// File: tb/tb_audio_frame_ctrl.sv
// tb_audio_frame_ctrl: directed bench with a pair/bit scoreboard for
// audio_frame_ctrl at default parameters, plus a second instance with
// SCK_HALF=2 for the fast-clock data check.
module tb_audio_frame_ctrl;

    localparam int H     = 4;
    localparam int FRAME = 4 * 16 * H;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } pend_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        sck, lrck, sdin, frame_start, underrun;

    logic        b_en, b_valid, b_ready, b_sck, b_lrck, b_sdin, b_fs, b_ur;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pend_t       pq[$];
    logic [1:0]  bitq[$];
    logic [1:0]  ebit;
    logic [31:0] exp_frame;
    logic        exp_ur;
    logic        sck_q, fall_now, low_ok;
    int          high_cnt, low_cnt;
    int          fs_count = 0, ur_count = 0, falls = 0, last_fs = 0;
    logic        per_chk = 1'b0;

    audio_frame_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .sck(sck),
        .lrck(lrck), .sdin(sdin), .frame_start(frame_start), .underrun(underrun)
    );

    audio_frame_ctrl #(.SCK_HALF(2)) dut2 (
        .clk(clk), .rst(rst), .en(b_en), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(b_valid), .sample_ready(b_ready), .sck(b_sck),
        .lrck(b_lrck), .sdin(b_sdin), .frame_start(b_fs), .underrun(b_ur)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_fs(input int limit);
        int n0 = fs_count;
        int t  = 0;
        while (fs_count == n0 && t < limit) begin
            tick();
            t++;
        end
        chk("fs_wait", fs_count != n0, 1'b1);
    endtask

    task automatic wait_falls(input int k, input int limit);
        int n0 = falls;
        int t  = 0;
        while (falls < n0 + k && t < limit) begin
            tick();
            t++;
        end
        chk("falls_wait", falls >= n0 + k, 1'b1);
    endtask

    task automatic offer(input logic [31:0] pair, input int limit);
        int t = 0;
        while (!sample_ready && t < limit) begin
            tick();
            t++;
        end
        chk("offer_ready", sample_ready, 1'b1);
        if (sample_ready) begin
            sample_l     = pair[31:16];
            sample_r     = pair[15:0];
            sample_valid = 1'b1;
            pq.push_back('{data: pair, acc: cyc + 1});
            tick();
            sample_valid = 1'b0;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_sck"}, sck, 1'b0);
        chk({tag, "_lrck"}, lrck, 1'b0);
        chk({tag, "_sdin"}, sdin, 1'b0);
    endtask

    // Monitor: checks every bit at the sck rising edge against the frame the
    // model expects, sck phase lengths, frame period and underrun.
    initial begin
        sck_q    = 1'b0;
        low_ok   = 1'b0;
        high_cnt = 0;
        low_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sck_q  = 1'b0;
                low_ok = 1'b0;
            end else begin
                fall_now = !sck && sck_q;
                if (sck && !sck_q) begin
                    if (low_ok) chk("sck_low", low_cnt, H);
                    high_cnt = 1;
                    chk("bit_expected", bitq.size() != 0, 1'b1);
                    if (bitq.size() != 0) begin
                        ebit = bitq.pop_front();
                        chk("sdin", sdin, ebit[0]);
                        chk("lrck", lrck, ebit[1]);
                    end
                end else if (fall_now) begin
                    chk("sck_high", high_cnt, H);
                    low_cnt = 1;
                    low_ok  = 1'b1;
                    falls++;
                end else if (sck) begin
                    high_cnt++;
                end else begin
                    low_cnt++;
                end
                if (frame_start) begin
                    fs_count++;
                    if (per_chk) chk("fs_period", cyc - last_fs, FRAME);
                    last_fs = cyc;
                    chk("bits_left_at_fs", bitq.size(), 0);
                    if (pq.size() != 0 && pq[0].acc < cyc) begin
                        exp_frame = pq[0].data;
                        void'(pq.pop_front());
                        exp_ur = 1'b0;
                    end else begin
                        exp_frame = 32'h0;
                        exp_ur    = 1'b1;
                    end
                    chk("underrun", underrun, exp_ur);
                    for (int i = 0; i < 32; i++)
                        bitq.push_back({(i >= 16) ? 1'b1 : 1'b0, exp_frame[31-i]});
                    if (!fall_now) low_ok = 1'b0;
                end
                if (underrun) begin
                    ur_count++;
                    chk("underrun_has_fs", frame_start, 1'b1);
                end
                sck_q = sck;
            end
        end
    end

    initial begin
        int          n0, tgt, t;
        int          fs_n, nb, fs1, last_rise;
        logic        bsck_q;
        logic [31:0] bbits, blr;

        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
        b_en = 1'b0; b_valid = 1'b0;
        ticks(3);
        chk_quiet("rst");
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_ur", underrun, 1'b0);
        chk("rst_ready", sample_ready, 1'b1);
        rst = 1'b0;
        tick();

        // single frame A5C3 / 0F0F
        n0 = fs_count;
        offer(32'hA5C3_0F0F, 5);
        chk("ready_after_accept", sample_ready, 1'b0);
        en = 1'b1;
        wait_fs(20);
        en = 1'b0;
        ticks(280);
        chk("one_frame", fs_count, n0 + 1);
        chk("frame_done", bitq.size(), 0);
        chk_quiet("idle1");
        chk("idle1_ready", sample_ready, 1'b1);

        // en dropped at bit 5: frame still completes
        n0 = fs_count;
        offer(32'h1234_8001, 5);
        en = 1'b1;
        wait_fs(20);
        wait_falls(5, 60);
        en = 1'b0;
        ticks(280);
        chk("no_trunc_fs", fs_count, n0 + 1);
        chk("no_trunc_bits", bitq.size(), 0);
        chk_quiet("idle2");

        // pair held across IDLE plays first after en
        n0 = fs_count;
        offer(32'h7FFF_8000, 5);
        ticks(20);
        chk("idle_hold_fs", fs_count, n0);
        chk("idle_hold_ready", sample_ready, 1'b0);
        en = 1'b1;
        wait_fs(20);
        per_chk = 1'b1;

        // continuous source, then stall
        offer(32'hDEAD_BEEF, 20);
        offer(32'h0001_FFFE, 300);
        offer(32'hC0DE_5A5A, 300);
        wait_fs(300);
        chk("no_underrun_yet", ur_count, 0);
        wait_fs(300);
        chk("underrun_count1", ur_count, 1);
        ticks(50);
        offer(32'h3C3C_C3C3, 10);
        wait_fs(300);

        // pair accepted on an underrun boundary waits for the next frame
        tgt = last_fs + FRAME;
        t = 0;
        while (cyc < tgt - 1 && t < 300) begin
            tick();
            t++;
        end
        chk("edge_align", cyc, tgt - 1);
        offer(32'h8888_1111, 1);
        wait_fs(300);
        chk("underrun_count2", ur_count, 2);
        wait_fs(300);
        en = 1'b0;
        per_chk = 1'b0;
        ticks(280);
        chk("boundary_pair_bits", bitq.size(), 0);
        chk_quiet("idle3");

        // reset mid-frame with nbuf full
        en = 1'b1;
        offer(32'h5555_AAAA, 10);
        wait_fs(20);
        offer(32'h9999_6666, 10);
        n0 = falls;
        wait_falls(20, 200);
        chk("pre_rst_full", sample_ready, 1'b0);
        rst = 1'b1;
        pq.delete();
        bitq.delete();
        tick();
        chk_quiet("rst2");
        chk("rst2_fs", frame_start, 1'b0);
        chk("rst2_ur", underrun, 1'b0);
        chk("rst2_ready", sample_ready, 1'b1);
        sample_l = 16'hFFFF; sample_r = 16'h0001; sample_valid = 1'b1;
        tick();
        rst = 1'b0;
        sample_valid = 1'b0;
        chk("rst_drops_pair", sample_ready, 1'b1);
        n0 = fs_count;
        ticks(40);
        chk("prime_wait_fs", fs_count, n0);
        chk("prime_wait_sck", sck, 1'b0);
        offer(32'h0F1E_2D3C, 5);
        wait_fs(20);
        en = 1'b0;
        ticks(280);
        chk("after_rst_bits", bitq.size(), 0);
        chk_quiet("idle4");

        // SCK_HALF = 2 instance
        chk("b_ready", b_ready, 1'b1);
        sample_l = 16'hA5C3; sample_r = 16'h0F0F; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_en = 1'b1;
        fs_n = 0; nb = 0; fs1 = 0; last_rise = -1; bsck_q = 1'b0;
        bbits = '0; blr = '0;
        for (int k = 0; k < 400 && fs_n < 2; k++) begin
            tick();
            if (b_fs) begin
                fs_n++;
                if (fs_n == 1) fs1 = cyc;
                else begin
                    chk("b_fs_period", cyc - fs1, 128);
                    chk("b_underrun", b_ur, 1'b1);
                end
            end
            if (b_sck && !bsck_q && fs_n == 1 && nb < 32) begin
                if (last_rise >= 0) chk("b_sck_period", cyc - last_rise, 4);
                last_rise = cyc;
                bbits[31-nb] = b_sdin;
                blr[31-nb]   = b_lrck;
                nb++;
            end
            bsck_q = b_sck;
        end
        b_en = 1'b0;
        chk("b_fs_count", fs_n, 2);
        chk("b_data", bbits, 32'hA5C3_0F0F);
        chk("b_lrck", blr, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_frame_ctrl.md
AUDIO_FRAME_CTRL -- requirements
Module: audio_frame_ctrl

Interface
REQ-001 SHALL have parameter SCK_HALF, default 4, clk cycles per half serial-clock period (legal 2..255).
REQ-002 SHALL have parameter SAMPLE_W, default 16, bits per channel sample.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port sample_l  input  SAMPLE_W  left sample, two's complement.
REQ-007 SHALL have port sample_r  input  SAMPLE_W  right sample, two's complement.
REQ-008 SHALL have port sample_valid  input  1  source holds a sample pair.
REQ-009 SHALL have port sample_ready  output  1  block accepts pair this cycle.
REQ-010 SHALL have port sck  output  1  serial bit clock to DAC.
REQ-011 SHALL have port lrck  output  1  channel select: 0 left, 1 right.
REQ-012 SHALL have port sdin  output  1  serial data, MSB first.
REQ-013 SHALL have port frame_start  output  1  one-clk pulse when a new frame is loaded.
REQ-014 SHALL have port underrun  output  1  one-clk pulse when a frame is loaded without a pending pair.

Function
REQ-015 SHALL hold a one-deep pair buffer (nbuf, flag nfull); sample_ready = ~nfull, driven directly from the register.
REQ-016 SHALL capture {sample_l,sample_r} into nbuf and set nfull on any cycle with sample_valid && sample_ready, in every state including IDLE.
REQ-017 SHALL implement FSM states IDLE, PRIME, RUN.
REQ-018 IDLE: sck=0, lrck=0, sdin=0; en=1 -> PRIME next cycle.
REQ-019 PRIME: outputs as IDLE; en=0 -> IDLE; nfull=1 -> load frame (REQ-022) and enter RUN.
REQ-020 RUN: divider div_cnt counts 0..SCK_HALF-1; at terminal count, div_cnt<=0 and sck toggles; bit period = 2*SCK_HALF clks; frame = 2*SAMPLE_W bits = 4*SAMPLE_W*SCK_HALF clks (256 at defaults).
REQ-021 RUN: on each sck falling toggle, if bit_cnt < 2*SAMPLE_W-1: bit_cnt++, shift register moves left one bit; otherwise frame boundary (REQ-022/023).
REQ-022 Frame load: shreg <= nbuf (left in upper half), nfull <= 0, bit_cnt <= 0, div_cnt <= 0, sck <= 0, frame_start pulses the same cycle.
REQ-023 Boundary: en=0 -> IDLE, no load, no pulse; en=1 and nfull=1 -> frame load; en=1 and nfull=0 -> frame load of all-zeros, nfull unchanged, underrun and frame_start both pulse.
REQ-024 A pair accepted on a boundary cycle with nfull=0 SHALL go to nbuf for the following frame, never into the current frame; underrun still pulses.
REQ-025 sdin = shreg MSB; lrck = (bit_cnt >= SAMPLE_W); both change only on frame load or sck falling toggles.
REQ-026 en deassertion mid-frame SHALL NOT truncate: the current frame completes, then IDLE.
REQ-027 nbuf SHALL be retained across IDLE; a pair held at IDLE SHALL be the first frame after the next en.

Reset
REQ-028 On rst=1 at a clk edge: state=IDLE, nfull=0, div_cnt=0, bit_cnt=0, shreg=0; sck=0, lrck=0, sdin=0, frame_start=0, underrun=0, sample_ready=1 on the following cycle.
REQ-029 Reset mid-frame SHALL abort immediately with no further pulses; rst overrides a simultaneous handshake (pair discarded).

Structure
REQ-030 Package audio_pkg SHALL hold the FSM state enum, SAMPLE_W default, and FRAME_BITS = 2*SAMPLE_W.
REQ-031 Divider SHALL be the sub-module sck_div (inputs clk, rst, run; outputs sck, fall_tick); buffer, FSM and shifter stay in audio_frame_ctrl.

Verification
REQ-032 Pair L=16'hA5C3, R=16'h0F0F, en=1 -> frame_start once; sdin over 32 sck falls = A5C3 then 0F0F MSB first; lrck low for 16 bits, then high for 16.
REQ-033 Defaults, source always valid -> frame_start period exactly 256 clks, sck period 8 clks, underrun never asserted.
REQ-034 Source stalls after first pair -> next boundary: underrun and frame_start pulse together, 32 zero bits on sdin; pair arriving mid-frame plays in the following frame.
REQ-035 en dropped at bit 5 -> remaining 27 bits still shift out, then sck/lrck/sdin = 0 and IDLE; no frame_start.
REQ-036 rst asserted at bit 20 with nfull=1 -> next cycle all outputs 0, sample_ready=1, nbuf empty; en=1 with no data waits in PRIME.
REQ-037 SCK_HALF=2 -> sck period 4 clks, frame 128 clks, data integrity as REQ-032.
